// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decoder with a valid/ready handshake.
// Single-cycle ops go straight to HOLD. MULT and DIV first spend a
// configurable number of cycles in BUSY, which stalls upstream while the
// iterative unit runs.
module alu_ctrl_seq #(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              illegal,
  output logic              busy,
  output logic              start
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  localparam logic [3:0] CODE_DIV = 4'b1010;

  // Decode result packed as {illegal, multi_cycle, code[3:0]}.
  function automatic logic [5:0] decode_op(input logic [1:0] op, input logic [5:0] fn);
    logic [5:0] res;
    res = 6'b00_0000;
    case (op)
      2'b00: res = 6'b00_0000;
      2'b01: res = 6'b00_0001;
      2'b11: res = 6'b00_0011;
      2'b10: begin
        case (fn)
          6'b100000: res = 6'b00_0000;
          6'b100010: res = 6'b00_0001;
          6'b100100: res = 6'b00_0010;
          6'b100101: res = 6'b00_0011;
          6'b100110: res = 6'b00_0100;
          6'b100111: res = 6'b00_0101;
          6'b101010: res = 6'b00_0110;
          6'b000000: res = 6'b00_0111;
          6'b000010: res = 6'b00_1000;
          6'b011000: res = 6'b01_1001;
          6'b011010: res = 6'b01_1010;
          default:   res = 6'b10_1111;
        endcase
      end
      default: res = 6'b10_1111;
    endcase
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              illegal_q, illegal_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;

  logic [5:0]        dec_s;
  logic              dec_illegal_s;
  logic              dec_multi_s;
  logic [3:0]        dec_code_s;
  logic              in_ready_s;
  logic              accept_s;

  // Handshake: readiness depends only on state and out_ready; flush blocks any accept.
  always_comb begin
    dec_s         = decode_op(aluop, funct);
    dec_illegal_s = dec_s[5];
    dec_multi_s   = dec_s[4];
    dec_code_s    = dec_s[3:0];
    in_ready_s    = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    accept_s      = in_valid && in_ready_s && !flush;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: flush wins, then a new accept, then the per-state rules.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else if (accept_s) begin
      state_d = dec_multi_s ? ST_BUSY : ST_HOLD;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_BUSY: begin
          // Count of one (or a defensive zero) means this is the last busy cycle.
          if ((cnt_q == CNT_ONE) || (cnt_q == CNT_ZERO)) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output/datapath next values: control word, illegal flag, busy counter and status flags.
  always_comb begin
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (flush) begin
      ctrl_d    = '0;
      illegal_d = 1'b0;
      cnt_d     = CNT_ZERO;
    end else if (accept_s) begin
      ctrl_d      = '0;
      ctrl_d[3:0] = dec_code_s;
      illegal_d   = dec_illegal_s;
      if (dec_multi_s) begin
        cnt_d = (dec_code_s == CODE_DIV) ? DIV_CNT : MUL_CNT;
      end else begin
        cnt_d = CNT_ZERO;
      end
    end else if ((state_q == ST_BUSY) && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
    // start marks only the first BUSY cycle, i.e. the one right after a multi-cycle accept.
    start_d     = accept_s && dec_multi_s;
    busy_d      = (state_d == ST_BUSY);
    out_valid_d = (state_d == ST_HOLD);
  end

  // Output and counter registers; cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
      cnt_q       <= CNT_ZERO;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign alucontrol = ctrl_q;
  assign illegal    = illegal_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Testbench for alu_ctrl_seq. A scoreboard queue holds the expected
// {illegal, alucontrol} for each accepted op. Directed checks cover latency,
// backpressure, flush and reset. A second instance with DIV_CYCLES = 1
// covers the minimum-latency case.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_valid1, out_ready;
  logic [1:0] aluop;
  logic [5:0] funct;

  logic       in_ready, out_valid, illegal, busy, start;
  logic [3:0] alucontrol;
  logic       in_ready1, out_valid1, illegal1, busy1, start1;
  logic [3:0] alucontrol1;

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  logic [4:0] sb_q[$];

  localparam int NVEC = 16;
  logic [7:0] vecs [NVEC] = '{
    8'b10_100000, 8'b10_100010, 8'b10_100100, 8'b10_100101,
    8'b10_100110, 8'b10_100111, 8'b10_101010, 8'b10_000000,
    8'b10_000010, 8'b10_011000, 8'b10_011010, 8'b10_111111,
    8'b10_000001, 8'b00_011010, 8'b01_100100, 8'b11_111111
  };

  alu_ctrl_seq #(.CTRL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
    .alucontrol(alucontrol), .illegal(illegal), .busy(busy), .start(start)
  );

  alu_ctrl_seq #(.CTRL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(1), .CNT_W(6)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid1), .in_ready(in_ready1),
    .aluop(aluop), .funct(funct), .out_valid(out_valid1), .out_ready(out_ready),
    .alucontrol(alucontrol1), .illegal(illegal1), .busy(busy1), .start(start1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected {illegal, code} straight from the decode table.
  function automatic logic [4:0] exp_word(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 5'b0_0000;
    if (op == 2'b01) return 5'b0_0001;
    if (op == 2'b11) return 5'b0_0011;
    case (fn)
      6'b100000: return 5'b0_0000;
      6'b100010: return 5'b0_0001;
      6'b100100: return 5'b0_0010;
      6'b100101: return 5'b0_0011;
      6'b100110: return 5'b0_0100;
      6'b100111: return 5'b0_0101;
      6'b101010: return 5'b0_0110;
      6'b000000: return 5'b0_0111;
      6'b000010: return 5'b0_1000;
      6'b011000: return 5'b0_1001;
      6'b011010: return 5'b0_1010;
      default:   return 5'b1_1111;
    endcase
  endfunction

  function automatic bit is_multi(input logic [1:0] op, input logic [5:0] fn);
    return (op == 2'b10) && ((fn == 6'b011000) || (fn == 6'b011010));
  endfunction

  // Scoreboard: pop on output handshake, push on input accept, clear on flush/reset.
  always @(negedge clk) begin
    logic [4:0] exp_w;
    if (!rst_n || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_val("sb_unexpected_out", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_w = sb_q.pop_front();
          n_pops++;
          check_val("sb_ctrl", {27'd0, illegal, alucontrol}, {27'd0, exp_w});
        end
      end
      if (in_valid && in_ready) sb_q.push_back(exp_word(aluop, funct));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op, wait (bounded) for in_ready, let it be accepted, check first-cycle status.
  task automatic send(input logic [1:0] op, input logic [5:0] fn, output int waits);
    aluop    = op;
    funct    = fn;
    in_valid = 1'b1;
    #1;
    waits = 0;
    while (!in_ready && waits < 100) begin
      tick();
      waits++;
    end
    if (waits >= 100) check_val("send_timeout", 32'(waits), 32'd0);
    tick();
    if (is_multi(op, fn)) begin
      check_val("multi_busy_c1", {31'd0, busy}, 32'd1);
      check_val("multi_start_c1", {31'd0, start}, 32'd1);
    end else begin
      check_val("single_ov_c1", {31'd0, out_valid}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  waits;
    bit  prev_multi;
    bit  seen_ov;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
    out_ready = 1'b1; aluop = 2'b00; funct = 6'b000000;

    // Reset asserted mid-cycle; outputs must respond immediately.
    #3 rst_n = 1'b0;
    #1;
    check_val("rst_ctrl", {28'd0, alucontrol}, 32'd0);
    check_val("rst_ov", {31'd0, out_valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_start", {31'd0, start}, 32'd0);
    check_val("rst_illegal", {31'd0, illegal}, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_val("idle_ov", {31'd0, out_valid}, 32'd0);
    check_val("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Decode sweep, back-to-back where the op kinds allow it.
    prev_multi = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      logic [7:0] v;
      v = vecs[i];
      send(v[7:6], v[5:0], waits);
      if (!prev_multi) check_val("b2b_no_bubble", 32'(waits), 32'd0);
      prev_multi = is_multi(v[7:6], v[5:0]);
    end
    in_valid = 1'b0;
    repeat (2) tick();

    // MULT sequencing.
    aluop = 2'b10; funct = 6'b011000; in_valid = 1'b1;
    #1;
    check_val("mul_acc_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check_val("mul_start", {31'd0, start}, {31'd0, (c == 1)});
      check_val("mul_busy", {31'd0, busy}, 32'd1);
      check_val("mul_in_ready", {31'd0, in_ready}, 32'd0);
      check_val("mul_ov", {31'd0, out_valid}, 32'd0);
      tick();
    end
    check_val("mul_ov_c5", {31'd0, out_valid}, 32'd1);
    check_val("mul_ctrl_c5", {28'd0, alucontrol}, 32'h9);
    check_val("mul_busy_c5", {31'd0, busy}, 32'd0);
    tick();

    // Backpressure: ADD held while SUB waits.
    out_ready = 1'b0;
    aluop = 2'b00; funct = 6'b000000; in_valid = 1'b1;
    tick();
    aluop = 2'b01;
    #1;
    for (int c = 0; c < 5; c++) begin
      check_val("bp_ov", {31'd0, out_valid}, 32'd1);
      check_val("bp_ctrl", {28'd0, alucontrol}, 32'h0);
      check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_val("bp_release_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_val("bp_sub_ctrl", {28'd0, alucontrol}, 32'h1);
    check_val("bp_sub_ov", {31'd0, out_valid}, 32'd1);
    tick();
    check_val("bp_idle_ov", {31'd0, out_valid}, 32'd0);

    // Flush in cycle 10 of a DIV; a new in_valid in that cycle is dropped.
    aluop = 2'b10; funct = 6'b011010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_val("fl_busy_c1", {31'd0, busy}, 32'd1);
    repeat (9) tick();
    flush = 1'b1; in_valid = 1'b1; aluop = 2'b00;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_val("fl_busy", {31'd0, busy}, 32'd0);
    check_val("fl_ov", {31'd0, out_valid}, 32'd0);
    check_val("fl_start", {31'd0, start}, 32'd0);
    check_val("fl_ctrl", {28'd0, alucontrol}, 32'h0);
    check_val("fl_in_ready", {31'd0, in_ready}, 32'd1);

    // Flush in IDLE with an in_valid present: the op must not be taken.
    aluop = 2'b01; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_val("fl_drop_ov", {31'd0, out_valid}, 32'd0);
    check_val("fl_drop_ctrl", {28'd0, alucontrol}, 32'h0);
    seen_ov = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid) seen_ov = 1'b1;
    end
    check_val("fl_no_ov", {31'd0, seen_ov}, 32'd0);

    // Reset in cycle 10 of a DIV.
    aluop = 2'b10; funct = 6'b011010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    check_val("rmid_busy", {31'd0, busy}, 32'd0);
    check_val("rmid_ov", {31'd0, out_valid}, 32'd0);
    check_val("rmid_ctrl", {28'd0, alucontrol}, 32'h0);
    tick();
    rst_n = 1'b1;
    seen_ov = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid) seen_ov = 1'b1;
    end
    check_val("rmid_no_ov", {31'd0, seen_ov}, 32'd0);

    // Minimum latency on the DIV_CYCLES = 1 instance.
    aluop = 2'b10; funct = 6'b011010; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check_val("min_start_c1", {31'd0, start1}, 32'd1);
    check_val("min_busy_c1", {31'd0, busy1}, 32'd1);
    check_val("min_ov_c1", {31'd0, out_valid1}, 32'd0);
    tick();
    check_val("min_start_c2", {31'd0, start1}, 32'd0);
    check_val("min_busy_c2", {31'd0, busy1}, 32'd0);
    check_val("min_ov_c2", {31'd0, out_valid1}, 32'd1);
    check_val("min_ctrl_c2", {28'd0, alucontrol1}, 32'hA);
    tick();

    // Every accepted op on the main instance must have come out.
    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    check_val("sb_pops", 32'(n_pops), 32'(NVEC + 3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, handshaked successor to the combinational ALU decoder. It decodes `aluop`/`funct` into a `CTRL_W`-bit ALU control word and holds it stable in an output register. It also sequences multi-cycle operations (MULT, DIV) with a configurable-latency busy counter. It sits between the ID/EX control stage and the ALU/iterative unit, stalling upstream while a multi-cycle op is in flight.

## Interface
- `CTRL_W`, 4: control word width; must be ≥ 4 (upper bits zero-padded).
- `MUL_CYCLES`, 4: busy cycles for MULT; range 1 .. 2^`CNT_W`-1.
- `DIV_CYCLES`, 32: busy cycles for DIV; range 1 .. 2^`CNT_W`-1.
- `CNT_W`, 6: busy counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous abort; clears state and outputs.
- `in_valid`  in  1  upstream presents `aluop`/`funct`.
- `in_ready`  out  1  block can accept this cycle.
- `aluop`  in  2  00 = add, 01 = sub, 10 = R-type (use `funct`), 11 = or (immediate-logical).
- `funct`  in  6  R-type function field; ignored unless `aluop` = 10.
- `out_valid`  out  1  `alucontrol` result is complete and valid.
- `out_ready`  in  1  downstream consumes the output.
- `alucontrol`  out  `CTRL_W`  registered control word.
- `illegal`  out  1  registered; the held op had an unknown funct.
- `busy`  out  1  multi-cycle op in progress.
- `start`  out  1  one-cycle pulse that kicks the iterative unit.

## Operation

**Decode.** For `aluop` 00/01/11 the output is ADD 0000 / SUB 0001 / OR 0011. For `aluop` = 10, decode `funct`:
- 100000 ADD → 0000
- 100010 SUB → 0001
- 100100 AND → 0010
- 100101 OR → 0011
- 100110 XOR → 0100
- 100111 NOR → 0101
- 101010 SLT → 0110
- 000000 SLL → 0111
- 000010 SRL → 1000
- 011000 MULT → 1001 (multi-cycle)
- 011010 DIV → 1010 (multi-cycle)
- any other funct → 1111 with `illegal` = 1, treated as single-cycle.

**State machine.** States are IDLE, BUSY and HOLD.
- `in_ready` = (state == IDLE) or (state == HOLD and `out_ready`).
- Accept happens when `in_valid` and `in_ready` are both high.
- Accept of a single-cycle op:
  - The decoded word and `illegal` are registered.
  - Next state is HOLD.
- Accept of a multi-cycle op:
  - The word is registered and next state is BUSY.
  - The counter loads `MUL_CYCLES` or `DIV_CYCLES`.
  - `start` = 1 for exactly the first BUSY cycle.
- BUSY:
  - The counter decrements each cycle.
  - At the edge where count == 1, the block moves to HOLD.
  - `alucontrol` is held stable throughout.
- HOLD:
  - `out_valid` = 1.
  - If `out_ready` is high and there is no accept, go to IDLE (`out_valid` drops next cycle).
  - If `out_ready` is high and an accept occurs, move directly to the new op's state (back-to-back, no bubble).
  - If `out_ready` = 0, stay in HOLD with all outputs stable.
- `busy` = (state == BUSY).
- `out_valid` = (state == HOLD).

## Timing

**Reset values.** While `rst_n` = 0, asynchronously:
- state = IDLE, count = 0.
- `alucontrol` = 0, `illegal` = 0.
- `out_valid` = 0, `busy` = 0, `start` = 0.
- `in_ready` = 1 (combinational from IDLE).

**Reset mid-operation.** A reset during BUSY or HOLD returns immediately to the reset values; no output handshake completes.

**Latency.**
- Single-cycle op: accepted in cycle 0, `out_valid` = 1 in cycle 1.
- Multi-cycle op with latency L: `busy` = 1 in cycles 1..L, `start` = 1 in cycle 1 only, `out_valid` = 1 in cycle L+1.
- L = 1 is legal: one BUSY cycle, with `start` and `busy` coincident.

**Flush.**
- `flush` takes priority over accept and handshake; it is ignored only while `rst_n` is low.
- Next cycle, all values match reset except that no asynchronous path is involved.
- Any `in_valid` in the flush cycle is dropped: `in_ready` is still computed, but no accept is registered.

**Other rules.**
- `in_ready` is combinational from state and `out_ready` only, never from `in_valid`.
- `in_valid` held with `in_ready` = 0 is legal. Upstream holds `aluop`/`funct` stable until accept.
- Outputs change only at clock edges, except through `rst_n`.

## Test plan
- **Reset and idle.** Assert `rst_n` = 0 mid-cycle, release, then idle 3 cycles.
  - Outputs immediately read `alucontrol` = 0, `out_valid` = 0, `busy` = 0, `in_ready` = 1.
- **Full decode sweep.** With `out_ready` = 1 and `in_valid` pulsed per vector, drive `aluop` = 10 and every listed funct, plus `aluop` = 00, 01 and 11.
  - Each `alucontrol` matches the decode table, 1 cycle after accept.
  - funct 111111 gives 1111 with `illegal` = 1.
  - Back-to-back accepts show no bubbles.
- **MULT sequencing.** With `MUL_CYCLES` = 4, accept funct 011000.
  - `start` = 1 in cycle 1, `busy` = 1 in cycles 1–4, `in_ready` = 0 in cycles 1–4.
  - `out_valid` = 1 with `alucontrol` = 1001 in cycle 5.
- **Backpressure.** With `out_ready` = 0, accept ADD, then hold for 5 cycles.
  - `out_valid` stays 1 and `alucontrol` stays 0000.
  - `in_ready` = 0 while a second `in_valid` (SUB) is held.
  - Raising `out_ready` accepts SUB in the same cycle; the next cycle shows 0001.
- **Flush and reset mid-op.** Accept DIV (`DIV_CYCLES` = 32), then assert `flush` in cycle 10.
  - Cycle 11 shows IDLE with `busy` = 0 and `out_valid` = 0.
  - Repeat using `rst_n` low in cycle 10: `busy` drops asynchronously and no `out_valid` ever appears.
- **Minimum latency.** With `DIV_CYCLES` = 1, accept DIV.
  - `start` and `busy` are both high in cycle 1 only.
  - `out_valid` = 1 in cycle 2 with `alucontrol` = 1010.
